// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: Pong ball position/direction owner, stepped once per 60 Hz ref_tick.
// Handles wall bounces, paddle hits, misses, serve delay and one-cycle scoring pulses.
// Optional feature: define BALL_SPEEDUP_EN to raise speed by one on each paddle hit,
// capped at MAX_SPEED. Without it the speed is the constant SPEED.

module ball_motion_ctrl #(
    parameter int unsigned H_ACTIVE       = 640,
    parameter int unsigned V_ACTIVE       = 480,
    parameter int unsigned BALL_SIZE      = 8,
    parameter int unsigned PADDLE_W       = 8,
    parameter int unsigned PADDLE_H       = 64,
    parameter int unsigned LEFT_PADDLE_X  = 16,
    parameter int unsigned RIGHT_PADDLE_X = 616,
    parameter int unsigned SPEED          = 2,
    parameter int unsigned MAX_SPEED      = 6,
    parameter int unsigned SERVE_TICKS    = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ref_tick,
    input  logic       pause,
    input  logic [9:0] pad_l_y,
    input  logic [9:0] pad_r_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       hit,
    output logic       score_l,
    output logic       score_r
);

    // 11-bit constants so every sum below has headroom and never wraps.
    localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0]  X_CTR  = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]  Y_CTR  = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [10:0] L_FACE = 11'(LEFT_PADDLE_X + PADDLE_W);
    localparam logic [10:0] R_FACE = 11'(RIGHT_PADDLE_X);
    localparam logic [10:0] BSZ    = 11'(BALL_SIZE);
    localparam logic [10:0] PH     = 11'(PADDLE_H);
    localparam logic [10:0] SPD0   = 11'(SPEED);

    localparam int unsigned CNT_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_TICKS - 1);

    typedef enum logic [1:0] {StServe, StPlay, StScore} state_e;

    state_e           state;
    logic [CNT_W-1:0] serve_cnt;
    logic             dx_right;
    logic             dy_down;
    logic             scorer_r;   // which side scores when SCORE completes
    logic [10:0]      speed;

`ifdef BALL_SPEEDUP_EN
    localparam logic [10:0] SPD_MAX = 11'(MAX_SPEED);
    logic [10:0] speed_q;
    assign speed = speed_q;
`else
    assign speed = SPD0;
`endif

    logic        tick_eff;
    logic [10:0] x, y, pl, pr;
    logic        ovl_l, ovl_r;
    logic        hit_l, hit_r, miss_l, miss_r;
    logic [9:0]  x_nxt, y_nxt;
    logic        dx_nxt, dy_nxt;

    assign tick_eff = ref_tick & ~pause;

    // One motion step computed from the pre-step position, paddles and directions.
    always_comb begin
        x  = {1'b0, ball_x};
        y  = {1'b0, ball_y};
        pl = {1'b0, pad_l_y};
        pr = {1'b0, pad_r_y};

        ovl_l  = (y + BSZ > pl) && (y < pl + PH);
        ovl_r  = (y + BSZ > pr) && (y < pr + PH);
        hit_l  = !dx_right && (x >= L_FACE) && (x < L_FACE + speed) && ovl_l;
        hit_r  = dx_right && (x + BSZ <= R_FACE) && (x + BSZ + speed > R_FACE) && ovl_r;
        miss_l = !dx_right && (x < speed) && !hit_l;
        miss_r = dx_right && (x + speed > X_MAX) && !hit_r;

        dx_nxt = dx_right;
        if (hit_l) begin
            x_nxt  = 10'(L_FACE);
            dx_nxt = 1'b1;
        end else if (hit_r) begin
            x_nxt  = 10'(R_FACE - BSZ);
            dx_nxt = 1'b0;
        end else if (miss_l) begin
            x_nxt = 10'd0;
        end else if (miss_r) begin
            x_nxt = 10'(X_MAX);
        end else if (dx_right) begin
            x_nxt = 10'(x + speed);
        end else begin
            x_nxt = 10'(x - speed);
        end

        dy_nxt = dy_down;
        if (!dy_down && (y < speed)) begin
            y_nxt  = 10'd0;
            dy_nxt = 1'b1;
        end else if (dy_down && (y + speed > Y_MAX)) begin
            y_nxt  = 10'(Y_MAX);
            dy_nxt = 1'b0;
        end else if (dy_down) begin
            y_nxt = 10'(y + speed);
        end else begin
            y_nxt = 10'(y - speed);
        end
    end

    // Serve/play/score sequencing with registered position and pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StServe;
            serve_cnt <= '0;
            ball_x    <= X_CTR;
            ball_y    <= Y_CTR;
            dx_right  <= 1'b1;
            dy_down   <= 1'b1;
            scorer_r  <= 1'b0;
            hit       <= 1'b0;
            score_l   <= 1'b0;
            score_r   <= 1'b0;
`ifdef BALL_SPEEDUP_EN
            speed_q   <= SPD0;
`endif
        end else begin
            hit     <= 1'b0;
            score_l <= 1'b0;
            score_r <= 1'b0;
            unique case (state)
                StServe: begin
                    if (tick_eff) begin
                        if (serve_cnt == SERVE_LAST) begin
                            serve_cnt <= '0;
                            state     <= StPlay;
                        end else begin
                            serve_cnt <= serve_cnt + 1'b1;
                        end
                    end
                end
                StPlay: begin
                    if (tick_eff) begin
                        ball_x   <= x_nxt;
                        ball_y   <= y_nxt;
                        dx_right <= dx_nxt;
                        dy_down  <= dy_nxt;
                        hit      <= hit_l | hit_r;
                        if (miss_l || miss_r) begin
                            state    <= StScore;
                            scorer_r <= miss_l;
                        end
`ifdef BALL_SPEEDUP_EN
                        if (hit_l || hit_r) begin
                            speed_q <= (speed_q < SPD_MAX) ? speed_q + 11'd1 : SPD_MAX;
                        end
`endif
                    end
                end
                StScore: begin
                    // Ticks arriving here are dropped; serve restarts with a fresh count.
                    score_r   <= scorer_r;
                    score_l   <= ~scorer_r;
                    ball_x    <= X_CTR;
                    ball_y    <= Y_CTR;
                    dx_right  <= ~scorer_r;
                    serve_cnt <= '0;
                    state     <= StServe;
`ifdef BALL_SPEEDUP_EN
                    speed_q   <= SPD0;
`endif
                end
                default: state <= StServe;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Self-checking bench for ball_motion_ctrl: directed scenarios plus random play
// compared cycle by cycle against a behavioural game model.

module tb_ball_motion_ctrl;

    localparam int XMAX = 632;
    localparam int YMAX = 472;
    localparam int XC = 316;
    localparam int YC = 236;
    localparam int LFACE = 24;
    localparam int RFACE = 616;
    localparam int BS = 8;
    localparam int PH = 64;
    localparam int SPD = 2;
    localparam int MAXSPD = 6;
    localparam int SERVE = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ref_tick = 1'b0;
    logic       pause = 1'b0;
    logic [9:0] pad_l_y = 10'd0;
    logic [9:0] pad_r_y = 10'd0;
    logic [9:0] ball_x, ball_y;
    logic       hit, score_l, score_r;

    int errors = 0;
    int checks = 0;

    // Behavioural model: phase 0 serve, 1 play, 2 score.
    int m_phase, m_cnt, m_x, m_y, m_vx, m_vy, m_spd;
    bit m_scorer_r, m_hit, m_sl, m_sr;

    ball_motion_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .ref_tick(ref_tick),
        .pause   (pause),
        .pad_l_y (pad_l_y),
        .pad_r_y (pad_r_y),
        .ball_x  (ball_x),
        .ball_y  (ball_y),
        .hit     (hit),
        .score_l (score_l),
        .score_r (score_r)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int s, nx, ny, pl, pr;
        bit ovl, ovr, hl, hr;
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_x = XC; m_y = YC; m_vx = 1; m_vy = 1;
            m_spd = SPD; m_scorer_r = 0; m_hit = 0; m_sl = 0; m_sr = 0;
            return;
        end
        m_hit = 0; m_sl = 0; m_sr = 0;
        if (m_phase == 2) begin
            if (m_scorer_r) m_sr = 1; else m_sl = 1;
            m_x = XC; m_y = YC; m_spd = SPD; m_cnt = 0; m_phase = 0;
            m_vx = m_scorer_r ? -1 : 1;
        end else if (ref_tick && !pause) begin
            if (m_phase == 0) begin
                if (m_cnt == SERVE - 1) begin m_cnt = 0; m_phase = 1; end
                else m_cnt++;
            end else begin
                s = m_spd; pl = int'(pad_l_y); pr = int'(pad_r_y);
                ovl = (m_y + BS > pl) && (m_y < pl + PH);
                ovr = (m_y + BS > pr) && (m_y < pr + PH);
                hl = (m_vx < 0) && (m_x >= LFACE) && (m_x - s < LFACE) && ovl;
                hr = (m_vx > 0) && (m_x + BS <= RFACE) && (m_x + BS + s > RFACE) && ovr;
                ny = m_y + m_vy * s;
                if (ny < 0) begin ny = 0; m_vy = 1; end
                else if (ny > YMAX) begin ny = YMAX; m_vy = -1; end
                nx = m_x + m_vx * s;
                if (hl) begin nx = LFACE; m_vx = 1; m_hit = 1; end
                else if (hr) begin nx = RFACE - BS; m_vx = -1; m_hit = 1; end
                else if (nx < 0) begin nx = 0; m_phase = 2; m_scorer_r = 1; end
                else if (nx > XMAX) begin nx = XMAX; m_phase = 2; m_scorer_r = 0; end
`ifdef BALL_SPEEDUP_EN
                if (m_hit) m_spd = (s + 1 > MAXSPD) ? MAXSPD : s + 1;
`endif
                m_x = nx; m_y = ny;
            end
        end
    endtask

    // Advance model and DUT one clock; inputs stay stable across the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ref_tick = 1'b1;
        cycle(); cycle();
        checks++;
        if ({ball_x, ball_y, hit, score_l, score_r} !== {10'd316, 10'd236, 3'b000}) begin
            errors++;
            $display("FAIL reset: got x=%0d y=%0d pulses=%b%b%b want x=316 y=236 pulses=000",
                     ball_x, ball_y, hit, score_l, score_r);
        end
        rst = 1'b0; ref_tick = 1'b0;
    endtask

    task automatic test_serve();
        pad_l_y = 10'd0; pad_r_y = 10'd0;
        for (int i = 1; i <= SERVE; i++) begin
            ref_tick = 1'b1; cycle();
            ref_tick = 1'b0;
            checks++;
            if (ball_x !== 10'd316 || ball_y !== 10'd236 || hit !== 1'b0) begin
                errors++;
                $display("FAIL serve_hold tick %0d: got (%0d,%0d) hit=%b want (316,236) hit=0",
                         i, ball_x, ball_y, hit);
            end
            cycle();
        end
        ref_tick = 1'b1; cycle(); ref_tick = 1'b0;
        checks++;
        if (ball_x !== 10'd318 || ball_y !== 10'd238) begin
            errors++;
            $display("FAIL serve_launch: got (%0d,%0d) want (318,238)", ball_x, ball_y);
        end
    endtask

    task automatic test_back_to_back();
        ref_tick = 1'b1;
        cycle();
        checks++;
        if (ball_x !== 10'd320 || ball_y !== 10'd240) begin
            errors++;
            $display("FAIL b2b_first: got (%0d,%0d) want (320,240)", ball_x, ball_y);
        end
        cycle();
        ref_tick = 1'b0;
        checks++;
        if (ball_x !== 10'd322 || ball_y !== 10'd242) begin
            errors++;
            $display("FAIL b2b_second: got (%0d,%0d) want (322,242)", ball_x, ball_y);
        end
    endtask

    task automatic test_pause();
        pause = 1'b1; ref_tick = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if (ball_x !== 10'd322 || ball_y !== 10'd242 || hit !== 1'b0) begin
                errors++;
                $display("FAIL pause %0d: got (%0d,%0d) hit=%b want (322,242) hit=0",
                         i, ball_x, ball_y, hit);
            end
        end
        pause = 1'b0; ref_tick = 1'b0;
    endtask

    task automatic test_midplay_reset();
        ref_tick = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        checks++;
        if ({ball_x, ball_y, hit, score_l, score_r} !== {10'd316, 10'd236, 3'b000}) begin
            errors++;
            $display("FAIL midplay_reset: got x=%0d y=%0d pulses=%b%b%b want 316 236 000",
                     ball_x, ball_y, hit, score_l, score_r);
        end
        // A cleared serve counter needs the full SERVE ticks again before motion.
        for (int i = 0; i < SERVE; i++) cycle();
        checks++;
        if (ball_x !== 10'd316 || ball_y !== 10'd236) begin
            errors++;
            $display("FAIL reset_serve_hold: got (%0d,%0d) want (316,236)", ball_x, ball_y);
        end
        cycle();
        ref_tick = 1'b0;
        checks++;
        if (ball_x !== 10'd318 || ball_y !== 10'd238) begin
            errors++;
            $display("FAIL reset_serve_launch: got (%0d,%0d) want (318,238)", ball_x, ball_y);
        end
    endtask

    task automatic test_score_drop();
        int budget;
        bit exp_r;
        budget = 0;
        ref_tick = 1'b1;
        while (m_phase != 2 && budget < 2000) begin
            pad_l_y = (m_y < 208) ? 10'd400 : 10'd0;
            pad_r_y = pad_l_y;
            cycle();
            budget++;
            checks++;
            if ({ball_x, ball_y, hit, score_l, score_r} !==
                {10'(m_x), 10'(m_y), m_hit, m_sl, m_sr}) begin
                errors++;
                $display("FAIL score_approach: got (%0d,%0d,%b%b%b) want (%0d,%0d,%b%b%b)",
                         ball_x, ball_y, hit, score_l, score_r, m_x, m_y, m_hit, m_sl, m_sr);
            end
        end
        checks++;
        if (m_phase != 2) begin
            errors++;
            $display("FAIL score_timeout: no miss within %0d cycles, ball (%0d,%0d)",
                     budget, ball_x, ball_y);
            ref_tick = 1'b0;
            return;
        end
        exp_r = m_scorer_r;
        // Tick held high through the SCORE cycle must be dropped.
        cycle();
        checks++;
        if ({ball_x, ball_y, score_l, score_r, hit} !==
            {10'd316, 10'd236, !exp_r, exp_r, 1'b0}) begin
            errors++;
            $display("FAIL score_pulse: got (%0d,%0d) l=%b r=%b hit=%b want (316,236) l=%b r=%b",
                     ball_x, ball_y, score_l, score_r, hit, !exp_r, exp_r);
        end
        for (int i = 0; i < SERVE; i++) begin
            cycle();
            checks++;
            if ({ball_x, ball_y, score_l, score_r} !== {10'd316, 10'd236, 2'b00}) begin
                errors++;
                $display("FAIL score_serve %0d: got (%0d,%0d) l=%b r=%b want (316,236) 0 0",
                         i, ball_x, ball_y, score_l, score_r);
            end
        end
        cycle();
        ref_tick = 1'b0;
        checks++;
        if (ball_x !== (exp_r ? 10'd314 : 10'd318)) begin
            errors++;
            $display("FAIL score_relaunch: got x=%0d want x=%0d", ball_x, exp_r ? 314 : 318);
        end
    endtask

    task automatic test_random();
        int pv, hits, scores;
        hits = 0; scores = 0;
        for (int i = 0; i < 12000; i++) begin
            ref_tick = ($urandom_range(0, 99) < 65);
            pause = ($urandom_range(0, 99) < 8);
            rst = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 3) != 0) begin
                pv = m_y - int'($urandom_range(0, 80));
                pad_l_y = (pv < 0) ? 10'd0 : 10'(pv);
                pv = m_y - int'($urandom_range(0, 80));
                pad_r_y = (pv < 0) ? 10'd0 : 10'(pv);
            end else begin
                pad_l_y = 10'($urandom_range(0, 416));
                pad_r_y = 10'($urandom_range(0, 416));
            end
            cycle();
            if (hit) hits++;
            if (score_l || score_r) scores++;
            checks++;
            if ({ball_x, ball_y, hit, score_l, score_r} !==
                {10'(m_x), 10'(m_y), m_hit, m_sl, m_sr}) begin
                errors++;
                $display("FAIL random cyc %0d: got (%0d,%0d,%b%b%b) want (%0d,%0d,%b%b%b)",
                         i, ball_x, ball_y, hit, score_l, score_r,
                         m_x, m_y, m_hit, m_sl, m_sr);
            end
        end
        rst = 1'b0; pause = 1'b0; ref_tick = 1'b0;
        checks++;
        if (hits == 0 || scores == 0) begin
            errors++;
            $display("FAIL random_activity: got hits=%0d scores=%0d want both nonzero",
                     hits, scores);
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_back_to_back();
        test_pause();
        test_midplay_reset();
        test_score_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
